// File: rtl/bus_responder_pkg.sv
// Purpose : shared address map and encodings for bus_responder.
//   - console register offsets inside the 4-byte I/O window
//   - reset-vector byte addresses
//   - STATUS bit indices
//   - open-bus read value
//   - region_t: the address decode result
// Ports   : none (package).
package bus_map;

  localparam logic [1:0] ConsoleData    = 2'd0;
  localparam logic [1:0] ConsoleStatus  = 2'd1;
  localparam logic [1:0] ConsoleCountLo = 2'd2;
  localparam logic [1:0] ConsoleCountHi = 2'd3;

  localparam logic [15:0] VectorLoAddr = 16'hFFFC;
  localparam logic [15:0] VectorHiAddr = 16'hFFFD;

  localparam logic [2:0] StatusFull     = 3'd0;
  localparam logic [2:0] StatusEmpty    = 3'd1;
  localparam logic [2:0] StatusOverflow = 3'd2;

  localparam logic [7:0] OpenBus = 8'hFF;

  typedef enum logic [1:0] {
    RegionRam,
    RegionVector,
    RegionConsole,
    RegionUnmapped
  } region_t;

endpackage

// File: rtl/bus_responder_if.sv
// Purpose : groups the CPU bus and console stream signals of bus_responder.
// Signals :
//   READ_write     CPU  -> resp : 1 = write cycle, 0 = read cycle
//   address_in     CPU  -> resp : bus address
//   data_in        CPU  -> resp : write data
//   data_out       resp -> CPU  : registered read data
//   console_data   resp -> sink : FIFO head byte
//   console_valid  resp -> sink : FIFO non-empty
//   console_ready  sink -> resp : sink accepts the head byte
//   bus_error      resp -> CPU  : sticky unmapped-access flag
// Console handshake: a byte transfers on every rising edge where
// console_valid && console_ready. While console_valid is high and
// console_ready is low, console_data holds stable. console_valid never
// depends combinationally on console_ready.
interface bus_responder_if;
  logic       READ_write;
  logic [15:0] address_in;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] console_data;
  logic       console_valid;
  logic       console_ready;
  logic       bus_error;

  modport slave (
    input  READ_write, address_in, data_in, console_ready,
    output data_out, console_data, console_valid, bus_error
  );

  modport master (
    output READ_write, address_in, data_in, console_ready,
    input  data_out, console_data, console_valid, bus_error
  );
endinterface

// File: rtl/bus_responder_sync_fifo.sv
// Purpose : single-clock FIFO holding the console transmit bytes.
// Ports   :
//   clk_i, rst_ni   clock, synchronous active-low reset (empties the FIFO)
//   push_i, data_i  enqueue request and byte; accepted when not full or
//                   when a pop happens in the same cycle
//   pop_i           dequeue request; ignored while empty
//   data_o          head entry, 0 while empty
//   full_o, empty_o, count_o  occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so push into a full FIFO is
  // legal when paired with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are visible.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/bus_responder.sv
// Purpose : responder on the far side of the cpu6502 external bus.
//   Decodes every cycle into on-chip RAM, reset-vector bytes, a console
//   I/O window (FIFO data, status, cycle counter lo/hi) or unmapped space,
//   and returns registered read data one cycle after the address.
// Ports   :
//   clk_in   single clock, rising edge
//   reset    synchronous active-low reset
//   bus      bus_responder_if.slave (CPU bus + console stream + bus_error)
// Build option: BUS_RESPONDER_UNMAPPED_TRAP_EN enables the sticky
//   bus_error flag; without it bus_error is tied low.
module bus_responder
  import bus_map::*;
#(
  parameter int          RAM_ADDR_WIDTH = 11,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] RESET_VECTOR   = 16'h0200,
  parameter logic [15:0] CONSOLE_BASE   = 16'hD000
) (
  input  logic           clk_in,
  input  logic           reset,
  bus_responder_if.slave bus
);
  localparam int RamBytes = 2 ** RAM_ADDR_WIDTH;
  localparam int CntW     = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]  mem_q [RamBytes];
  logic [7:0]  data_out_q, data_out_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  snap_q, snap_d;
  logic        overflow_q, overflow_d;

  region_t     region;
  logic [1:0]  io_off;
  logic        wr_en;
  logic        push_req, pop;
  logic        fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [7:0]  status;

  // Address decode; RAM wins if it ever overlaps the other regions.
  always_comb begin
    region = RegionUnmapped;
    if (bus.address_in[15:RAM_ADDR_WIDTH] == '0) begin
      region = RegionRam;
    end else if (bus.address_in == VectorLoAddr || bus.address_in == VectorHiAddr) begin
      region = RegionVector;
    end else if (bus.address_in[15:2] == CONSOLE_BASE[15:2]) begin
      region = RegionConsole;
    end
  end

  assign io_off = bus.address_in[1:0];
  // Reset suppresses every side effect of the cycle it lands on.
  assign wr_en  = reset && bus.READ_write;

  assign push_req = wr_en && region == RegionConsole && io_off == ConsoleData;
  assign pop      = bus.console_valid && bus.console_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (reset),
    .push_i  (push_req),
    .data_i  (bus.data_in),
    .pop_i   (pop),
    .data_o  (bus.console_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.console_valid = (fifo_count != '0);

  always_comb begin
    status = '0;
    status[StatusFull]     = fifo_full;
    status[StatusEmpty]    = fifo_empty;
    status[StatusOverflow] = overflow_q;
  end

  // Read mux plus next state for counter, snapshot and overflow.
  always_comb begin
    data_out_d = OpenBus;
    cnt_d      = cnt_q + 16'd1;
    snap_d     = snap_q;
    overflow_d = overflow_q;
    case (region)
      RegionRam:    data_out_d = mem_q[bus.address_in[RAM_ADDR_WIDTH-1:0]];
      RegionVector: data_out_d = bus.address_in[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
      RegionConsole: begin
        case (io_off)
          ConsoleData:   data_out_d = 8'h00;
          ConsoleStatus: begin
            data_out_d = status;
            if (bus.READ_write) overflow_d = 1'b0;
          end
          ConsoleCountLo: begin
            data_out_d = cnt_q[7:0];
            // Snapshot pairs the high byte with the low byte just read.
            if (!bus.READ_write) snap_d = cnt_q[15:8];
            if (bus.READ_write)  cnt_d  = 16'h0000;
          end
          default:       data_out_d = snap_q;
        endcase
      end
      default:      data_out_d = OpenBus;
    endcase
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      data_out_q <= 8'h00;
      cnt_q      <= 16'h0000;
      snap_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM is not cleared by reset; writes land after the read mux sampled
  // the old contents, giving read-before-write.
  always_ff @(posedge clk_in) begin
    if (wr_en && region == RegionRam)
      mem_q[bus.address_in[RAM_ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  assign bus.data_out = data_out_q;

`ifdef BUS_RESPONDER_UNMAPPED_TRAP_EN
  logic bus_error_q;
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      bus_error_q <= 1'b0;
    end else if (region == RegionUnmapped ||
                 (bus.READ_write && region == RegionVector)) begin
      bus_error_q <= 1'b1;
    end
  end
  assign bus.bus_error = bus_error_q;
`else
  assign bus.bus_error = 1'b0;
`endif
endmodule

// File: tb/tb_bus_responder.sv
// Purpose : self-checking bench for bus_responder. Directed bus sequences
//   followed by random traffic, all compared each cycle against a
//   behavioural model of the memory map and console FIFO.
module tb_bus_responder;
  localparam int Depth = 8;
`ifdef BUS_RESPONDER_UNMAPPED_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bus_responder_if bus_if();

  bus_responder dut (
    .clk_in (clk),
    .reset  (reset_n),
    .bus    (bus_if.slave)
  );

  // ---------------- scoreboard / model state ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  ram_m [2048];
  logic [15:0] cnt_m;
  logic [7:0]  snap_m;
  logic [7:0]  dout_m;
  bit          ovf_m;
  bit          berr_m;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies one bus cycle to the model using pre-edge state.
  task automatic model_cycle(input bit rst, input bit we, input logic [15:0] a,
                             input logic [7:0] d, input bit rdy);
    logic [7:0] rd;
    bit full_b, pop;
    if (!rst) begin
      exp_q.delete();
      dout_m = 8'h00; ovf_m = 1'b0; cnt_m = 16'h0; snap_m = 8'h00; berr_m = 1'b0;
      return;
    end
    full_b = (exp_q.size() == Depth);
    pop    = (exp_q.size() != 0) && rdy;
    if (a < 16'h0800)       rd = ram_m[a[10:0]];
    else if (a == 16'hFFFC) rd = 8'h00;
    else if (a == 16'hFFFD) rd = 8'h02;
    else if (a >= 16'hD000 && a <= 16'hD003) begin
      case (a[1:0])
        2'd0:    rd = 8'h00;
        2'd1:    rd = {5'b0, ovf_m, exp_q.size() == 0, full_b};
        2'd2:    rd = cnt_m[7:0];
        default: rd = snap_m;
      endcase
    end else begin
      rd = 8'hFF;
      if (TrapEn) berr_m = 1'b1;
    end
    if (TrapEn && we && (a == 16'hFFFC || a == 16'hFFFD)) berr_m = 1'b1;
    dout_m = rd;
    if (we && a < 16'h0800) ram_m[a[10:0]] = d;
    if (!we && a == 16'hD002) snap_m = cnt_m[15:8];
    cnt_m = (we && a == 16'hD002) ? 16'h0 : cnt_m + 16'd1;
    if (we && a == 16'hD001) ovf_m = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (we && a == 16'hD000) begin
      if (!full_b || pop) exp_q.push_back(d);
      else ovf_m = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives one cycle and checks the outputs at
  // the next falling edge.
  task automatic step(input bit rst, input bit we, input logic [15:0] a,
                      input logic [7:0] d, input bit rdy);
    reset_n              = rst;
    bus_if.READ_write    = we;
    bus_if.address_in    = a;
    bus_if.data_in       = d;
    bus_if.console_ready = rdy;
    model_cycle(rst, we, a, d, rdy);
    @(posedge clk);
    @(negedge clk);
    check_eq("data_out", {8'h0, bus_if.data_out}, {8'h0, dout_m});
    check_eq("console_valid", {15'h0, bus_if.console_valid}, {15'h0, exp_q.size() != 0});
    check_eq("console_data", {8'h0, bus_if.console_data},
             {8'h0, (exp_q.size() != 0) ? exp_q[0] : 8'h00});
    check_eq("bus_error", {15'h0, bus_if.bus_error}, {15'h0, berr_m});
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 16'hFFFC, 8'h00, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    reset_n = 1'b0;
    bus_if.READ_write = 1'b0;
    bus_if.address_in = 16'hFFFC;
    bus_if.data_in = 8'h00;
    bus_if.console_ready = 1'b0;
    @(negedge clk);

    // Reset state.
    step(1'b0, 1'b0, 16'hFFFC, 8'h00, 1'b0);
    step(1'b0, 1'b0, 16'hFFFC, 8'h00, 1'b0);

    // RAM fill, then directed RAM and vector reads.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 16'(i), 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 16'h07FF, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 16'h0010, 8'h5A, 1'b0);
    step(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
    check_eq("ram_read_5a", {8'h0, bus_if.data_out}, 16'h005A);
    step(1'b1, 1'b0, 16'hFFFC, 8'h00, 1'b0);
    check_eq("vector_lo", {8'h0, bus_if.data_out}, 16'h0000);
    step(1'b1, 1'b0, 16'hFFFD, 8'h00, 1'b0);
    check_eq("vector_hi", {8'h0, bus_if.data_out}, 16'h0002);

    // FIFO fill, overflow, overflow clear, in-order drain.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'hD000, 8'(8'h41 + i), 1'b0);
    step(1'b1, 1'b0, 16'hD001, 8'h00, 1'b0);
    check_eq("status_full", {8'h0, bus_if.data_out}, 16'h0001);
    step(1'b1, 1'b1, 16'hD000, 8'h49, 1'b0);
    step(1'b1, 1'b0, 16'hD001, 8'h00, 1'b0);
    check_eq("status_ovf", {8'h0, bus_if.data_out}, 16'h0005);
    step(1'b1, 1'b1, 16'hD001, 8'h00, 1'b0);
    step(1'b1, 1'b0, 16'hD001, 8'h00, 1'b0);
    check_eq("status_ovf_clr", {8'h0, bus_if.data_out}, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_valid", {15'h0, bus_if.console_valid}, 16'h0001);
      check_eq("drain_byte", {8'h0, bus_if.console_data}, 16'(8'h41 + i));
      idle(1'b1);
    end
    check_eq("drain_empty", {15'h0, bus_if.console_valid}, 16'h0000);
    step(1'b1, 1'b0, 16'hD001, 8'h00, 1'b1);
    check_eq("status_empty", {8'h0, bus_if.data_out}, 16'h0002);

    // Push and pop together on a full FIFO.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'hD000, 8'(8'h10 + i), 1'b0);
    step(1'b1, 1'b1, 16'hD000, 8'h77, 1'b1);
    step(1'b1, 1'b0, 16'hD001, 8'h00, 1'b0);
    check_eq("full_push_pop", {8'h0, bus_if.data_out}, 16'h0001);
    check_eq("full_push_pop_head", {8'h0, bus_if.console_data}, 16'h0011);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Counter clear and lo/hi snapshot across a carry.
    step(1'b1, 1'b1, 16'hD002, 8'h00, 1'b0);
    for (int i = 0; i < 16'h1FF; i++) idle(1'b0);
    step(1'b1, 1'b0, 16'hD002, 8'h00, 1'b0);
    check_eq("count_lo", {8'h0, bus_if.data_out}, 16'h00FF);
    step(1'b1, 1'b0, 16'hD003, 8'h00, 1'b0);
    check_eq("count_hi_snap", {8'h0, bus_if.data_out}, 16'h0001);

    // Reset with bytes queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hD000, 8'(8'hA0 + i), 1'b0);
    step(1'b0, 1'b1, 16'hD000, 8'hEE, 1'b0);
    check_eq("rst_valid", {15'h0, bus_if.console_valid}, 16'h0000);
    check_eq("rst_data_out", {8'h0, bus_if.data_out}, 16'h0000);
    step(1'b1, 1'b0, 16'hD002, 8'h00, 1'b0);
    check_eq("rst_counter", {8'h0, bus_if.data_out}, 16'h0000);
    step(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
    check_eq("ram_keeps_5a", {8'h0, bus_if.data_out}, 16'h005A);

    // Unmapped read and bus_error stickiness.
    step(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0);
    check_eq("unmapped_ff", {8'h0, bus_if.data_out}, 16'h00FF);
    check_eq("bus_error_set", {15'h0, bus_if.bus_error}, {15'h0, TrapEn});
    idle(1'b0);
    check_eq("bus_error_sticky", {15'h0, bus_if.bus_error}, {15'h0, TrapEn});
    step(1'b0, 1'b0, 16'hFFFC, 8'h00, 1'b0);
    check_eq("bus_error_rst", {15'h0, bus_if.bus_error}, 16'h0000);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    a = 16'($urandom_range(0, 31));
        2:       a = 16'h07FF;
        3, 4:    a = 16'hD000;
        5:       a = 16'hD001;
        6:       a = 16'hD002;
        7:       a = 16'hD003;
        8:       a = $urandom_range(0, 1) ? 16'hFFFC : 16'hFFFD;
        default: begin
          case ($urandom_range(0, 3))
            0:       a = 16'h0800;
            1:       a = 16'h8000;
            2:       a = 16'hD004;
            default: a = 16'hFFFF;
          endcase
        end
      endcase
      step($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)), a,
           8'($urandom), 1'($urandom_range(0, 1)));
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory/peripheral responder on the far end of the cpu6502 external bus (address_out, data_out, READ_write, data_in).
- Decodes each bus cycle into one of:
  - on-chip RAM
  - reset-vector ROM bytes
  - console transmit port backed by a FIFO, drained through a valid/ready handshake
  - free-running cycle counter
- Returns registered read data to the CPU one cycle after the address.

Parameters:
- RAM_ADDR_WIDTH, 11, RAM size is 2**RAM_ADDR_WIDTH bytes, mapped from 0x0000.
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2.
- RESET_VECTOR, 16'h0200, value returned at 0xFFFC (low byte) and 0xFFFD (high byte).
- CONSOLE_BASE, 16'hD000, base address of the 4-byte I/O window.

Ports:
- clk_in  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- READ_write  in  1  from CPU; 1 = write cycle, 0 = read cycle.
- address_in  in  16  CPU address_out.
- data_in  in  8  CPU data_out (write data).
- data_out  out  8  read data to CPU data_in; registered.
- console_data  out  8  FIFO head byte.
- console_valid  out  1  FIFO non-empty.
- console_ready  in  1  downstream accepts head byte this cycle.
- bus_error  out  1  sticky unmapped-access flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clock edge):
  - data_out=0x00, FIFO empty, console_valid=0, console_data=0x00.
  - overflow flag=0, cycle counter=0, high-byte snapshot=0x00, bus_error=0.
  - RAM contents are not reset.
  - Reset asserted mid-operation discards FIFO contents and ignores that cycle's bus access.
- Every cycle out of reset, the current address is decoded.
- Read latency:
  - data_out at edge N+1 reflects the address at edge N, whatever READ_write is.
  - On a write cycle the value is the pre-write contents (read-before-write for RAM).
- RAM region, address < 2**RAM_ADDR_WIDTH:
  - Write stores data_in at edge.
  - Read returns mem[address].
- 0xFFFC / 0xFFFD: read RESET_VECTOR[7:0] / [15:8]; writes ignored.
- CONSOLE_BASE+0 (DATA):
  - Write pushes data_in into the FIFO.
  - If the FIFO is full and no pop happens the same cycle: byte dropped, overflow flag set (sticky).
  - Read returns 0x00.
- CONSOLE_BASE+1 (STATUS):
  - Read returns {5'b0, overflow, empty, full} (bit0=full, bit1=empty, bit2=overflow).
  - Any write clears overflow.
- CONSOLE_BASE+2 (COUNT_LO):
  - Read returns counter[7:0] and snapshots counter[15:8] in the same edge.
  - Any write clears the counter; it reads 0 on the next cycle, then resumes incrementing.
- CONSOLE_BASE+3 (COUNT_HI):
  - Read returns the snapshot; writes ignored.
- Counter: 16-bit, +1 per cycle, wraps 0xFFFF->0x0000.
- All other addresses: read 0xFF, writes ignored.
- FIFO rules:
  - Pop happens when console_valid && console_ready.
  - Push into an empty FIFO becomes visible (console_valid=1) on the following cycle; no combinational bypass.
  - Simultaneous push and pop when full: both succeed, count unchanged, no overflow.
  - Simultaneous push and pop with 1 entry: the new byte becomes head.
  - console_data holds stable while console_valid=1 && console_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: BUS_RESPONDER_UNMAPPED_TRAP_EN.
- Defined:
  - bus_error sets on any read or write to an unmapped address, and on a write to 0xFFFC/0xFFFD.
  - It stays set until reset.
  - Reads of unmapped addresses still return 0xFF.
- Undefined: bus_error tied to 0; no extra flop.

Decomposition:
- Package bus_map:
  - CONSOLE_DATA/STATUS/COUNT_LO/COUNT_HI offsets.
  - Vector addresses 0xFFFC/0xFFFD.
  - Status bit indices (StatusFull, StatusEmpty, StatusOverflow).
  - Open-bus value 0xFF.
  - Region enum region_t (RegionRam, RegionVector, RegionConsole, RegionUnmapped).
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count) holds the console FIFO.
- Decode, counter and read mux stay in bus_responder.

Test Plan:
- Write 0x5A to 0x0010, then read 0x0010 -> data_out=0x5A one cycle after the read address; read 0xFFFC/0xFFFD -> 0x00/0x02.
- With console_ready=0, write 0x41..0x48 to 0xD000 -> STATUS reads 0x01. A 9th write 0x49 -> STATUS 0x05. Write 0xD001 -> STATUS 0x01. Raise ready -> bytes 0x41..0x48 in order, then console_valid=0, STATUS 0x02.
- FIFO full with console_ready=1, write 0x77 same cycle -> head pops, 0x77 enqueued, overflow stays 0.
- Write 0xD002, wait 0x1FF cycles, read 0xD002 then 0xD003 -> low byte and the 0x01 snapshot stay consistent even if the counter carries between the two reads.
- Pull reset low while 3 bytes are queued -> next cycle console_valid=0, data_out=0x00, counter=0; RAM still holds the prior 0x5A.
- With BUS_RESPONDER_UNMAPPED_TRAP_EN, read 0x8000 -> data_out=0xFF, bus_error=1 until reset. Without the macro -> bus_error stays 0.
